// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
// Arbitrates the single HPS transmit path between N_SRC result buffers.
// A ready bank is granted in round-robin order. The scheduler then drives the
// TX unit's select, headcount, enable and clear lines, waits for frame
// completion or a watchdog/HPS abort, and returns a per-source done or abort
// pulse.
//
// Ports:
//   clk_in         system clock
//   rst_n          asynchronous active-low reset
//   src_ready      per-bank "complete frame held" level
//   src_headcount  per-bank line count, bank i at [i*UINT8_WIDTH +: UINT8_WIDTH]
//   src_done       one-cycle pulse, frame of the granted bank fully sent
//   src_abort      one-cycle pulse, frame of the granted bank aborted
//   tx_en          enable to the TX unit
//   tx_clear       Clear_buff to the TX unit, held CLR_CYCLES after each frame
//   tx_sel         index of the granted bank
//   tx_headcount   latched headcount of the granted bank
//   tx_done        TX unit frame-complete pulse
//   tx_wd_trigger  TX unit watchdog fired
//   hps_abort      HPS software abort request
//   busy           high whenever the scheduler is not idle
//   err_count      saturating count of aborted frames
module tx_frame_scheduler #(
  parameter int N_SRC       = 2,
  parameter int SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int UINT8_WIDTH = 8,
  parameter int CLR_CYCLES  = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             src_ready,
  input  logic [N_SRC*UINT8_WIDTH-1:0] src_headcount,
  output logic [N_SRC-1:0]             src_done,
  output logic [N_SRC-1:0]             src_abort,
  output logic                         tx_en,
  output logic                         tx_clear,
  output logic [SEL_W-1:0]             tx_sel,
  output logic [UINT8_WIDTH-1:0]       tx_headcount,
  input  logic                         tx_done,
  input  logic                         tx_wd_trigger,
  input  logic                         hps_abort,
  output logic                         busy,
  output logic [UINT8_WIDTH-1:0]       err_count
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ACTIVE,
    DONE,
    ABORT,
    CLEAR
  } state_t;

  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [SEL_W-1:0]         last_q, last_d;
  logic [UINT8_WIDTH-1:0]   hc_q, hc_d;
  logic [UINT8_WIDTH-1:0]   err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     en_q, en_d;
  logic                     clr_q, clr_d;
  logic                     busy_q, busy_d;
  logic [N_SRC-1:0]         done_q, done_d;
  logic [N_SRC-1:0]         abort_q, abort_d;

  logic                     found;
  logic [SEL_W-1:0]         grant_idx;

  // Round-robin search: first set ready bit starting just after last grant.
  always_comb begin
    int unsigned idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = 32'(last_q) + 1 + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && src_ready[idx]) begin
        found     = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hc_d    = hc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = grant_idx;
          hc_d    = src_headcount[grant_idx*UINT8_WIDTH +: UINT8_WIDTH];
          state_d = GRANT;
        end
      end
      GRANT: state_d = ACTIVE;
      ACTIVE: begin
        if (tx_done) begin
          state_d = DONE;
        end else if (tx_wd_trigger || hps_abort) begin
          state_d = ABORT;
          // Counted on entry so err_count moves together with src_abort.
          if (err_q != '1) err_d = err_q + 1'b1;
        end
      end
      DONE, ABORT: begin
        state_d = CLEAR;
        cnt_d   = CNT_W'(CLR_CYCLES - 1);
        last_d  = sel_q;
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode.
    en_d   = (state_d == ACTIVE);
    clr_d  = (state_d == CLEAR);
    busy_d = (state_d != IDLE);
    for (int unsigned i = 0; i < N_SRC; i++) begin
      done_d[i]  = (state_d == DONE)  && (sel_d == SEL_W'(i));
      abort_d[i] = (state_d == ABORT) && (sel_d == SEL_W'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_SRC - 1);
      hc_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hc_q    <= hc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign src_done     = done_q;
  assign src_abort    = abort_q;
  assign tx_en        = en_q;
  assign tx_clear     = clr_q;
  assign tx_sel       = sel_q;
  assign tx_headcount = hc_q;
  assign busy         = busy_q;
  assign err_count    = err_q;

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Arbitrates the single HPS transmit path between N_SRC result buffers (FILO banks). Each bank raises a ready flag with its line count.
- Grants one bank round-robin and drives the TX unit's select, headcount, enable and clear. It then waits for frame completion or a watchdog/HPS abort, and returns a per-source done or abort pulse.
- Sits between the plate-result buffers and the TX unit inside the AHIM bridge.

Parameters:
- N_SRC, 2, number of requesting buffers (2..8).
- SEL_W, $clog2(N_SRC) (min 1), width of tx_sel.
- UINT8_WIDTH, 8, headcount width (matches ahim_config_pkg).
- CLR_CYCLES, 2, cycles tx_clear is held after each frame (1..15).

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_ready  in  N_SRC  bank i holds a complete frame; level signal.
- src_headcount  in  N_SRC*UINT8_WIDTH  line count of bank i at slice [i*8+:8].
- src_done  out  N_SRC  one-cycle pulse: bank i frame fully sent.
- src_abort  out  N_SRC  one-cycle pulse: bank i frame aborted.
- tx_en  out  1  enable to TX unit.
- tx_clear  out  1  Clear_buff to TX unit.
- tx_sel  out  SEL_W  index of the granted bank (data mux select).
- tx_headcount  out  UINT8_WIDTH  latched headcount of the granted bank.
- tx_done  in  1  TX unit frame-complete pulse.
- tx_wd_trigger  in  1  TX unit watchdog fired.
- hps_abort  in  1  HPS software abort request (level or pulse).
- busy  out  1  high in every state except IDLE.
- err_count  out  UINT8_WIDTH  saturating count of aborted frames.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=N_SRC-1, err_count=0, and every output 0.
- States: IDLE, GRANT, ACTIVE, DONE, ABORT, CLEAR. All outputs are registered.
- IDLE:
  - If any src_ready bit is set, search starting at (last_grant+1) mod N_SRC and take the first set bit.
  - Latch that index into tx_sel and its src_headcount slice into tx_headcount, then go to GRANT.
  - hps_abort, tx_done and tx_wd_trigger are ignored in IDLE.
- GRANT: exactly 1 cycle with tx_en=0. This guarantees the TX unit sees a clean 0->1 edge on tx_en. Next state is ACTIVE.
- ACTIVE: tx_en=1, and tx_sel/tx_headcount are held stable. Exits, in priority order:
  1. tx_done=1: go to DONE.
  2. tx_wd_trigger=1 or hps_abort=1: go to ABORT.
  3. Otherwise stay in ACTIVE.
  - When tx_done and an abort source are high in the same cycle, tx_done wins.
- DONE: 1 cycle. tx_en=0 and src_done[tx_sel]=1. Next state is CLEAR.
- ABORT: 1 cycle. tx_en=0 and src_abort[tx_sel]=1. err_count increments, saturating at 255. Next state is CLEAR.
- CLEAR:
  - tx_clear=1 for exactly CLR_CYCLES cycles, counted by an internal counter.
  - last_grant takes tx_sel on entry.
  - After the final clear cycle, go to IDLE with tx_clear=0. The next grant cannot occur before the first IDLE cycle.
- Latched values: changes on src_ready or src_headcount after GRANT are ignored until the frame ends. A deasserted src_ready during ACTIVE does not abort the frame.
- Zero-length frame: headcount 0 is still granted, since a header-only transfer is legal.
- Fairness: with all sources continuously ready, grants rotate 0,1,...,N_SRC-1,0. No source waits more than N_SRC-1 frames.
- Minimum frame-to-frame gap is 1 (GRANT) + 1 (DONE/ABORT) + CLR_CYCLES + 1 (IDLE) cycles.
- Only one bit of src_done|src_abort is ever high, and only in DONE or ABORT.

Test Plan:
- Single source: src_ready=01, headcount[0]=5 -> tx_sel=0, tx_headcount=5, tx_en rises 2 cycles after ready. On tx_done: src_done=01 for 1 cycle, tx_clear high 2 cycles, busy low afterwards.
- Round-robin: src_ready=11 held across 4 frames, each ended by tx_done -> grant order 0,1,0,1 and src_done pulses 01,10,01,10.
- Watchdog abort: during ACTIVE assert tx_wd_trigger -> src_abort[sel]=1, src_done stays 0, err_count 0->1, tx_clear pulses, return to IDLE.
- Simultaneous tx_done and hps_abort in the same cycle -> DONE path taken, err_count unchanged.
- Saturation: 260 consecutive aborts -> err_count stops at 255.
- Reset mid-frame: drop rst_n during ACTIVE -> tx_en, tx_clear, busy, src_done and src_abort go to 0 immediately. After release, first grant with src_ready=11 goes to source 0.
